// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM activation store: default geometry and the
// read-sequencer state encoding.
package lstm_pkg;

  localparam int DEF_ADDR     = 12;
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM      = 53;
  localparam int DEF_TIMESTEP = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/lstm_skid_fifo2.sv
// Two-entry FIFO used to absorb downstream backpressure behind a
// registered-read memory. A push into a full FIFO is accepted only with a pop.
module lstm_skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         push_ok_s;
  logic         pop_ok_s;

  // qualify requests against current occupancy
  always_comb begin
    pop_ok_s  = pop && (count_r != 2'd0);
    push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
  end

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_r[i] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign count = count_r;

endmodule

// File: rtl/lstm_act_reader.sv
// Streams one timestep of activations out of memory port B as a valid/ready
// stream, hiding the memory's registered read behind a 2-entry buffer.
module lstm_act_reader
  import lstm_pkg::*;
#(
  parameter int ADDR     = DEF_ADDR,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM      = DEF_NUM,
  parameter int TIMESTEP = DEF_TIMESTEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDR-1:0]  ts_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ADDR-1:0]  mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready
);

  localparam logic [ADDR-1:0] TS_LIM   = ADDR'(TIMESTEP);
  localparam logic [ADDR-1:0] LAST_IDX = ADDR'(NUM - 1);

  rd_state_e       state_r, state_s;
  logic [ADDR-1:0] base_r, base_s, idx_r, idx_s, mem_addr_r, mem_addr_s;
  logic            p1_vld_r, p1_last_r, p2_vld_r, p2_last_r;
  logic            issue_s, issue_last_s;
  logic            busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic            pop_s, credit_s, fifo_empty_s, fifo_full_s;
  logic [1:0]      fifo_count_s;
  logic [2:0]      load_s;
  logic [WIDTH:0]  fifo_dout_s;

  // credit: words buffered after this edge's pop plus reads still in the memory pipe
  always_comb begin
    pop_s    = !fifo_empty_s && i_ready;
    load_s   = {1'b0, fifo_count_s} + {2'b00, p1_vld_r} + {2'b00, p2_vld_r} - {2'b00, pop_s};
    credit_s = !(fifo_full_s && !pop_s) && (load_s < 3'd2);
  end

  // next-state, address generation and status
  always_comb begin
    state_s      = state_r;
    base_s       = base_r;
    idx_s        = idx_r;
    mem_addr_s   = mem_addr_r;
    issue_s      = 1'b0;
    issue_last_s = 1'b0;
    busy_s       = busy_r;
    done_s       = 1'b0;
    err_s        = err_r;
    case (state_r)
      ST_IDLE: begin
        // done_r gating drops a start that lands in the completion cycle
        if (start && !done_r) begin
          if (ts_sel < TS_LIM) begin
            base_s       = ADDR'(ts_sel * NUM);
            mem_addr_s   = ADDR'(ts_sel * NUM);
            idx_s        = ADDR'(1);
            issue_s      = 1'b1;
            issue_last_s = (NUM == 1);
            busy_s       = 1'b1;
            err_s        = 1'b0;
            state_s      = (NUM == 1) ? ST_DRAIN : ST_ISSUE;
          end else begin
            err_s  = 1'b1;
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (credit_s) begin
          mem_addr_s   = base_r + idx_r;
          issue_s      = 1'b1;
          issue_last_s = (idx_r == LAST_IDX);
          idx_s        = idx_r + ADDR'(1);
          state_s      = (idx_r == LAST_IDX) ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s && !p1_vld_r && !p2_vld_r) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // datapath registers and two-stage read-in-flight pipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r     <= '0;
      idx_r      <= '0;
      mem_addr_r <= '0;
      p1_vld_r   <= 1'b0;
      p1_last_r  <= 1'b0;
      p2_vld_r   <= 1'b0;
      p2_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      base_r     <= base_s;
      idx_r      <= idx_s;
      mem_addr_r <= mem_addr_s;
      p1_vld_r   <= issue_s;
      p1_last_r  <= issue_last_s;
      p2_vld_r   <= p1_vld_r;
      p2_last_r  <= p1_last_r;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  lstm_skid_fifo2 #(.W(WIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (p2_vld_r),
    .din   ({p2_last_r, mem_rdata}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign mem_addr = mem_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign o_data   = fifo_dout_s[WIDTH-1:0];
  assign o_last   = fifo_dout_s[WIDTH];
  assign o_valid  = !fifo_empty_s;

endmodule

// File: tb/tb_lstm_act_reader.sv
// Randomised bench for lstm_act_reader against a queue of expected beats
// built from timestep/word arithmetic, with a behavioural registered memory.
module tb_lstm_act_reader;

  localparam int ADDR  = 12;
  localparam int WIDTH = 32;
  localparam int NUM   = 53;
  localparam int TS    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADDR-1:0]  ts_sel;
  logic             busy, done, err;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic [WIDTH-1:0] o_data;
  logic             o_valid, o_last;
  logic             i_ready;

  lstm_act_reader #(.ADDR(ADDR), .WIDTH(WIDTH), .NUM(NUM), .TIMESTEP(TS)) dut (
    .clk(clk), .rst(rst), .start(start), .ts_sel(ts_sel), .busy(busy), .done(done),
    .err(err), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .o_data(o_data),
    .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  // memory preloaded with its own address, one-cycle registered read
  always @(posedge clk) mem_rdata <= {{(WIDTH-ADDR){1'b0}}, mem_addr};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH:0]   exp_q[$];
  int               cyc_n = 0, beats = 0, done_cnt = 0;
  int               last_xfer_cyc = 0, done_cyc = 0, first_valid_cyc = -1, c_start = 0;
  int               rdy_mode = 0, hold_cnt = 0;
  bit               auto_restart = 1'b0;
  logic             stall_prev = 1'b0, last_prev = 1'b0;
  logic [WIDTH-1:0] data_prev = '0;

  task automatic load_exp(input int ts);
    for (int i = 0; i < NUM; i++) exp_q.push_back({(i == NUM - 1), WIDTH'(ts * NUM + i)});
  endtask

  // one clock: drive inputs at negedge and score the beat that the next posedge transfers
  task automatic cyc(input logic st, input logic [ADDR-1:0] ts);
    logic [WIDTH:0] e;
    @(negedge clk);
    cyc_n++;
    case (rdy_mode)
      1: i_ready = 1'($urandom_range(0, 1));
      2: begin
        i_ready = (hold_cnt == 0);
        if (hold_cnt > 0) hold_cnt--;
      end
      default: i_ready = 1'b1;
    endcase
    start  = st;
    ts_sel = ts;
    if (stall_prev) begin
      check_eq("hold_valid", o_valid, 1);
      check_eq("hold_data", o_data, data_prev);
      check_eq("hold_last", o_last, last_prev);
    end
    if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    if (o_valid && i_ready) begin
      check_eq("beat_expected", exp_q.size() > 0 ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("beat_data", o_data, e[WIDTH-1:0]);
        check_eq("beat_last", o_last, e[WIDTH]);
      end
      beats++;
      if (o_last) last_xfer_cyc = cyc_n;
    end
    stall_prev = o_valid && !i_ready;
    data_prev  = o_data;
    last_prev  = o_last;
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
      if (auto_restart) begin
        start  = 1'b1;
        ts_sel = ADDR'(1);
      end
    end
  endtask

  task automatic kick(input int ts);
    if (ts < TS) load_exp(ts);
    beats = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    cyc(1'b1, ADDR'(ts));
    c_start = cyc_n;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      cyc(1'b0, '0);
      k++;
    end
    check_eq("done_seen", done_cnt > 0 ? 1 : 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; ts_sel = '0; i_ready = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_o_data", o_data, 0);
    check_eq("rst_o_valid", o_valid, 0);
    check_eq("rst_o_last", o_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b1;

    // full-rate stream of timestep 1
    rdy_mode = 0;
    kick(1);
    cyc(1'b0, '0);
    check_eq("t1_first_addr", mem_addr, NUM);
    check_eq("t1_busy", busy, 1);
    wait_done(400);
    check_eq("t1_latency", first_valid_cyc - c_start, 3);
    check_eq("t1_done_after_last", done_cyc - last_xfer_cyc, 2);
    check_eq("t1_beats", beats, NUM);
    check_eq("t1_leftover", exp_q.size(), 0);
    check_eq("t1_busy_end", busy, 0);
    idle(5);
    check_eq("t1_done_once", done_cnt, 1);

    // random backpressure, timestep 0
    rdy_mode = 1;
    kick(0);
    wait_done(800);
    check_eq("t2_beats", beats, NUM);
    check_eq("t2_leftover", exp_q.size(), 0);
    idle(3);
    check_eq("t2_done_once", done_cnt, 1);

    // downstream stalled for 20 cycles from the start
    rdy_mode = 2;
    hold_cnt = 20;
    kick(0);
    repeat (19) cyc(1'b0, '0);
    check_eq("t3_valid", o_valid, 1);
    check_eq("t3_data", o_data, 0);
    check_eq("t3_addr", mem_addr, 1);
    check_eq("t3_busy", busy, 1);
    wait_done(400);
    check_eq("t3_beats", beats, NUM);
    check_eq("t3_leftover", exp_q.size(), 0);
    rdy_mode = 0;

    // out-of-range timestep
    kick(TS);
    cyc(1'b0, '0);
    check_eq("t4_err", err, 1);
    check_eq("t4_done", done, 1);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_valid", o_valid, 0);
    idle(5);
    check_eq("t4_done_once", done_cnt, 1);
    check_eq("t4_no_beats", beats, 0);
    check_eq("t4_err_sticky", err, 1);
    kick(1);
    cyc(1'b0, '0);
    check_eq("t4_err_clear", err, 0);
    check_eq("t4_busy_again", busy, 1);
    wait_done(400);
    check_eq("t4_beats", beats, NUM);

    // starts mid-stream and in the done cycle are ignored
    kick(0);
    repeat (20) cyc(1'b0, '0);
    cyc(1'b1, ADDR'(1));
    auto_restart = 1'b1;
    wait_done(400);
    auto_restart = 1'b0;
    idle(10);
    check_eq("t5_beats", beats, NUM);
    check_eq("t5_leftover", exp_q.size(), 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_done_once", done_cnt, 1);

    // asynchronous reset at beat 10
    kick(1);
    k = 0;
    while (beats < 10 && k < 200) begin
      cyc(1'b0, '0);
      k++;
    end
    check_eq("t6_reached_10", beats, 10);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_mem_addr", mem_addr, 0);
    check_eq("t6_o_data", o_data, 0);
    check_eq("t6_o_valid", o_valid, 0);
    check_eq("t6_o_last", o_last, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", done, 0);
    check_eq("t6_err", err, 0);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rdy_mode = 1;
    kick(0);
    wait_done(800);
    check_eq("t6_beats", beats, NUM);
    check_eq("t6_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
